bus_demux2: RTL and testbench
=============================

BUS_DEMUX2 -- requirements
Module: bus_demux2

Interface
REQ-001 Parameter WIDTH, default 32: data width of write data and response data.
REQ-002 Parameter ADDR_WIDTH, default 32: request address width.
REQ-003 Parameter S1_BASE, default 32'h1100_0000: lowest address routed to target 1.
REQ-004 Parameter S1_LIMIT, default 32'h1100_FFFF: highest address routed to target 1 (used only under REQ-024).
REQ-005 Parameter DEPTH, default 4, power of two: maximum number of outstanding requests.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 req_valid, req_ready  in/out  1 each  upstream request handshake.
REQ-009 req_addr  in  ADDR_WIDTH, req_we  in  1, req_wdata  in  WIDTH  upstream request fields.
REQ-010 rsp_valid  out  1, rsp_data  out  WIDTH, rsp_err  out  1  upstream response, one per accepted request; the master always accepts it.
REQ-011 For N in {0,1}: sN_req_valid out 1, sN_req_ready in 1, sN_req_addr out ADDR_WIDTH, sN_req_we out 1, sN_req_wdata out WIDTH  downstream request ports.
REQ-012 For N in {0,1}: sN_rsp_valid in 1, sN_rsp_ready out 1, sN_rsp_data in WIDTH  downstream response ports.

Function
REQ-013 Decode: target 1 when req_addr >= S1_BASE, otherwise target 0.
REQ-014 Request path combinational: sN_req_addr/we/wdata = req_*; sN_req_valid = req_valid and decode==N and order FIFO not full.
REQ-015 req_ready = decoded target's sN_req_ready and order FIFO not full; a request is accepted when req_valid and req_ready are both high.
REQ-016 Each accepted request pushes its 2-bit tag (0=s0, 1=s1, 2=error) into an order FIFO of DEPTH entries.
REQ-017 Full check uses the registered count only: no push while full, even when a pop occurs in the same cycle.
REQ-018 sN_rsp_ready is high only when the FIFO is non-empty and the head tag equals N; both are low when the FIFO is empty.
REQ-019 On sN_rsp_valid and sN_rsp_ready: next cycle rsp_valid=1, rsp_data=sN_rsp_data, rsp_err=0; the head is popped. Latency is 1 cycle.
REQ-020 rsp_valid is a single-cycle pulse per response; otherwise rsp_valid=0, and rsp_data holds its last value.
REQ-021 Simultaneous push and pop: count unchanged; read and write pointers both advance, wrapping modulo DEPTH.
REQ-022 A response from the non-head target is not accepted; that target stalls until its tag reaches the head. This enforces in-order responses.

Reset
REQ-023 While rst_n=0: FIFO pointers and count = 0, rsp_valid=0, rsp_data=0, rsp_err=0. In-flight tags are discarded; responses the slaves return after reset are not forwarded, because the FIFO is empty.

Configuration
REQ-024 Macro BUS_DEMUX_DECERR_EN defined:
- req_addr > S1_LIMIT decodes to error.
- The request is driven to neither slave; req_ready = FIFO not full.
- Tag 2 is pushed.
- When tag 2 reaches the head, it pops with no slave handshake. Next cycle: rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-025 Macro undefined: every address >= S1_BASE goes to target 1, S1_LIMIT is unused, and rsp_err is constant 0.

Verification
REQ-026 Single read: req to 32'h0000_0100, s0 ready; s0 responds 32'hDEAD_BEEF -> s0_req_valid high in the accept cycle; rsp_valid=1 with rsp_data=32'hDEAD_BEEF exactly 1 cycle after the s0 response handshake.
REQ-027 Ordering: requests to s0 then s1 back-to-back; s1 responds first with 32'h1111_1111 and holds, then s0 responds 32'h2222_2222 -> s1_rsp_ready=0 until the s0 response completes; rsp_data sequence is 2222_2222 then 1111_1111.
REQ-028 Full: 4 requests accepted with no responses -> req_ready=0 on the 5th. Same cycle, 1st response handshakes -> 5th still blocked that cycle and accepted the next cycle.
REQ-029 Reset mid-operation: 2 outstanding, rst_n pulsed low asynchronously -> rsp_valid=0 immediately; afterwards s0_rsp_ready=s1_rsp_ready=0 and a new request is accepted normally.
REQ-030 With BUS_DEMUX_DECERR_EN: req to 32'h2000_0000 -> no sN_req_valid; rsp_valid=1, rsp_err=1, rsp_data=0 one cycle after it reaches the head. Without the macro -> routed to s1, rsp_err=0.

Source files
------------

// File: rtl/bus_demux2.sv
// Two-target address demux with an in-order response return path.
// Optional decode-error target enabled by BUS_DEMUX_DECERR_EN.
module bus_demux2 #(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h1100_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_LIMIT   = 32'h1100_FFFF,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  s0_req_valid,
  input  logic                  s0_req_ready,
  output logic [ADDR_WIDTH-1:0] s0_req_addr,
  output logic                  s0_req_we,
  output logic [WIDTH-1:0]      s0_req_wdata,
  input  logic                  s0_rsp_valid,
  output logic                  s0_rsp_ready,
  input  logic [WIDTH-1:0]      s0_rsp_data,
  output logic                  s1_req_valid,
  input  logic                  s1_req_ready,
  output logic [ADDR_WIDTH-1:0] s1_req_addr,
  output logic                  s1_req_we,
  output logic [WIDTH-1:0]      s1_req_wdata,
  input  logic                  s1_rsp_valid,
  output logic                  s1_rsp_ready,
  input  logic [WIDTH-1:0]      s1_rsp_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {TAG_S0 = 2'd0, TAG_S1 = 2'd1, TAG_ERR = 2'd2} tag_e;

  tag_e           dec_tag;
  tag_e           head_tag;
  tag_e           tags_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           full, empty, tgt_rdy;
  logic           push, pop, pop0, pop1, pop_err;
  logic           rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    dec_tag = TAG_S0;
    if (req_addr >= S1_BASE) dec_tag = TAG_S1;
`ifdef BUS_DEMUX_DECERR_EN
    if (req_addr > S1_LIMIT) dec_tag = TAG_ERR;
`endif
  end

`ifndef BUS_DEMUX_DECERR_EN
  logic unused_limit;
  assign unused_limit = ^S1_LIMIT;
`endif

  // Full is judged on the registered count alone, so a same-cycle pop never frees a slot.
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    case (dec_tag)
      TAG_S0:  tgt_rdy = s0_req_ready;
      TAG_S1:  tgt_rdy = s1_req_ready;
      default: tgt_rdy = 1'b1;
    endcase
  end

  assign req_ready    = tgt_rdy && !full;
  assign push         = req_valid && req_ready;

  assign s0_req_valid = req_valid && (dec_tag == TAG_S0) && !full;
  assign s0_req_addr  = req_addr;
  assign s0_req_we    = req_we;
  assign s0_req_wdata = req_wdata;
  assign s1_req_valid = req_valid && (dec_tag == TAG_S1) && !full;
  assign s1_req_addr  = req_addr;
  assign s1_req_we    = req_we;
  assign s1_req_wdata = req_wdata;

  // Only the target owning the oldest outstanding tag may return a response.
  assign head_tag     = tags_q[rd_ptr_q];
  assign s0_rsp_ready = !empty && (head_tag == TAG_S0);
  assign s1_rsp_ready = !empty && (head_tag == TAG_S1);
  assign pop0         = s0_rsp_valid && s0_rsp_ready;
  assign pop1         = s1_rsp_valid && s1_rsp_ready;
`ifdef BUS_DEMUX_DECERR_EN
  assign pop_err      = !empty && (head_tag == TAG_ERR);
`else
  assign pop_err      = 1'b0;
`endif
  assign pop          = pop0 || pop1 || pop_err;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    rsp_data_d = rsp_data_q;
    if (pop1)         rsp_data_d = s1_rsp_data;
    else if (pop0)    rsp_data_d = s0_rsp_data;
    else if (pop_err) rsp_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (push) tags_q[wr_ptr_q] <= dec_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= pop;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef BUS_DEMUX_DECERR_EN
  logic rsp_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= pop_err;
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_demux2.sv
// Bench for bus_demux2: vector table for decode/routing, scoreboard for responses,
// plus hand sequences for ordering, full, reset and slave backpressure.
module tb_bus_demux2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        s0_req_valid, s0_req_ready, s0_req_we, s0_rsp_valid, s0_rsp_ready;
  logic [31:0] s0_req_addr, s0_req_wdata, s0_rsp_data;
  logic        s1_req_valid, s1_req_ready, s1_req_we, s1_rsp_valid, s1_rsp_ready;
  logic [31:0] s1_req_addr, s1_req_wdata, s1_rsp_data;

  bus_demux2 dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_addr(s0_req_addr),
    .s0_req_we(s0_req_we), .s0_req_wdata(s0_req_wdata),
    .s0_rsp_valid(s0_rsp_valid), .s0_rsp_ready(s0_rsp_ready), .s0_rsp_data(s0_rsp_data),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_addr(s1_req_addr),
    .s1_req_we(s1_req_we), .s1_req_wdata(s1_req_wdata),
    .s1_rsp_valid(s1_rsp_valid), .s1_rsp_ready(s1_rsp_ready), .s1_rsp_data(s1_rsp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb [$];   // {err, data}

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          tgt;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs [8];

`ifdef BUS_DEMUX_DECERR_EN
  localparam int HI_TGT = 2;
`else
  localparam int HI_TGT = 1;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      logic [32:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got=%0h exp=none", {rsp_err, rsp_data});
      end else begin
        e = sb.pop_front();
        if ({rsp_err, rsp_data} !== e) begin
          errors++;
          $display("FAIL rsp_payload got=%0h exp=%0h", {rsp_err, rsp_data}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Drive one request at a negedge, check routing, let it be accepted at the next posedge.
  task automatic send(input logic [31:0] a, input logic we, input logic [31:0] wd, input int tgt);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    #1;
    chk("req_ready", req_ready, 1);
    chk("s0_req_valid", s0_req_valid, tgt == 0);
    chk("s1_req_valid", s1_req_valid, tgt == 1);
    chk("req_fields", {s0_req_addr, s1_req_wdata}, {a, wd});
    chk("req_we", {s0_req_we, s1_req_we}, {we, we});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Slave n returns d while its tag is at the head; response must appear one cycle later.
  task automatic respond(input int n, input logic [31:0] d);
    if (n == 0) begin s0_rsp_valid = 1'b1; s0_rsp_data = d; end
    else        begin s1_rsp_valid = 1'b1; s1_rsp_data = d; end
    sb.push_back({1'b0, d});
    #1;
    chk("rsp_ready_head", (n == 0) ? s0_rsp_ready : s1_rsp_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s0_rsp_valid = 1'b0; s1_rsp_valid = 1'b0;
    chk("rsp_latency", rsp_valid, 1);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_hold", rsp_data, d);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,         0,      32'hDEAD_BEEF};
    vecs[1] = '{32'h10FF_FFFF, 1'b1, 32'hA5A5_0001, 0,      32'h0000_0001};
    vecs[2] = '{32'h1100_0000, 1'b0, 32'h0,         1,      32'h1234_5678};
    vecs[3] = '{32'h1100_FFFF, 1'b1, 32'h5A5A_0002, 1,      32'h8765_4321};
    vecs[4] = '{32'h0000_0000, 1'b0, 32'h0,         0,      32'h0F0F_0F0F};
    vecs[5] = '{32'h1101_0000, 1'b0, 32'h0,         HI_TGT, 32'hC0DE_0005};
    vecs[6] = '{32'h2000_0000, 1'b1, 32'h7777_0006, HI_TGT, 32'hC0DE_0006};
    vecs[7] = '{32'hFFFF_FFFF, 1'b0, 32'h0,         HI_TGT, 32'hC0DE_0007};

    rst_n = 1'b0;
    req_valid = 0; req_addr = 0; req_we = 0; req_wdata = 0;
    s0_req_ready = 1; s1_req_ready = 1;
    s0_rsp_valid = 0; s0_rsp_data = 0; s1_rsp_valid = 0; s1_rsp_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_data}, 34'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rsp_ready", {s0_rsp_ready, s1_rsp_ready}, 2'b00);
    chk("idle_req_ready", req_ready, 1);

    foreach (vecs[i]) begin
      send(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].tgt);
      if (vecs[i].tgt == 2) begin
        sb.push_back({1'b1, 32'h0});
        @(negedge clk);
        chk("decerr_rsp", {rsp_valid, rsp_err}, 2'b11);
        @(negedge clk);
        chk("decerr_pulse", rsp_valid, 0);
      end else begin
        respond(vecs[i].tgt, vecs[i].rdata);
      end
    end

    // Ordering: s1 answers first but must wait behind s0.
    send(32'h0000_0200, 1'b0, 32'h0, 0);
    send(32'h1100_0010, 1'b0, 32'h0, 1);
    s1_rsp_valid = 1'b1; s1_rsp_data = 32'h1111_1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("order_s1_blocked", s1_rsp_ready, 0);
      @(negedge clk);
      chk("order_no_rsp", rsp_valid, 0);
    end
    s0_rsp_valid = 1'b1; s0_rsp_data = 32'h2222_2222;
    sb.push_back({1'b0, 32'h2222_2222});
    #1;
    chk("order_ready", {s0_rsp_ready, s1_rsp_ready}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    s0_rsp_valid = 1'b0;
    chk("order_first", {rsp_valid, rsp_data}, {1'b1, 32'h2222_2222});
    sb.push_back({1'b0, 32'h1111_1111});
    chk("order_s1_now", s1_rsp_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s1_rsp_valid = 1'b0;
    chk("order_second", {rsp_valid, rsp_data}, {1'b1, 32'h1111_1111});
    @(negedge clk);

    // Full: four outstanding, fifth blocked even while a pop happens.
    for (int k = 0; k < 4; k++) send(32'h0000_0300 + k, 1'b0, 32'h0, 0);
    req_valid = 1'b1; req_addr = 32'h0000_0400;
    #1;
    chk("full_blocked", {req_ready, s0_req_valid}, 2'b00);
    s0_rsp_valid = 1'b1; s0_rsp_data = 32'h3000_0000;
    sb.push_back({1'b0, 32'h3000_0000});
    #1;
    chk("full_pop_same_cycle", {s0_rsp_ready, req_ready}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    s0_rsp_valid = 1'b0;
    chk("full_pop_rsp", rsp_valid, 1);
    chk("full_next_accept", {req_ready, s0_req_valid}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) respond(0, 32'h3000_0000 + k);

    // Slave backpressure reflects straight through to req_ready.
    s1_req_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h1100_0000;
    #1;
    chk("s1_backpressure", {req_ready, s1_req_valid}, 2'b01);
    req_valid = 1'b0; s1_req_ready = 1'b1;
    @(negedge clk);

    // Reset mid-operation with two outstanding and a response in flight.
    send(32'h0000_0500, 1'b0, 32'h0, 0);
    send(32'h1100_0500, 1'b0, 32'h0, 1);
    s0_rsp_valid = 1'b1; s0_rsp_data = 32'h5555_5555;
    @(posedge clk);
    #2;
    chk("pre_reset_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h5555_5555});
    rst_n = 1'b0;
    #1;
    chk("async_reset_rsp", {rsp_valid, rsp_data}, 33'h0);
    @(negedge clk);
    s0_rsp_valid = 1'b0;
    s1_rsp_valid = 1'b1; s1_rsp_data = 32'h7777_7777;
    rst_n = 1'b1;
    #1;
    chk("post_reset_rsp_ready", {s0_rsp_ready, s1_rsp_ready}, 2'b00);
    @(negedge clk);
    chk("stale_not_forwarded", rsp_valid, 0);
    s1_rsp_valid = 1'b0;
    send(32'h0000_0600, 1'b0, 32'h0, 0);
    respond(0, 32'hCAFE_F00D);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
